// File: rtl/ddr4_ca_dly_ctrl.sv
// Dynamic delay-line controller for the DDR4 CA output IODs: steps or reloads one
// lane per request and keeps a shadow tap count for every lane.
module ddr4_ca_dly_ctrl #(
  parameter  int NUM_LANES     = 14,
  parameter  int TAP_W         = 8,
  parameter  int TX_DELAY_INIT = 1,
  parameter  int MOVE_GAP      = 2,
  localparam int LANE_W        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                       i_fab_clk,
  input  logic                       i_arst,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic [LANE_W-1:0]          i_req_lane,
  input  logic [TAP_W-1:0]           i_req_tap,
  input  logic                       i_req_load,
  output logic                       o_done,
  output logic                       o_done_err,
  output logic [NUM_LANES-1:0]       o_delay_line_move,
  output logic [NUM_LANES-1:0]       o_delay_line_direction,
  output logic [NUM_LANES-1:0]       o_delay_line_load,
  input  logic [NUM_LANES-1:0]       i_delay_line_out_of_range,
  output logic [NUM_LANES*TAP_W-1:0] o_cur_tap
);

  localparam int                GAP_W    = $clog2(MOVE_GAP + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(MOVE_GAP - 1);
  localparam logic [TAP_W-1:0]  TAP_INIT = TAP_W'(TX_DELAY_INIT);
  localparam logic [LANE_W:0]   LANE_LIM = (LANE_W + 1)'(NUM_LANES);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_MOVE, S_GAP, S_DONE} state_t;

  state_t               r_state, w_state_next;
  logic                 r_rdy_en;
  logic [LANE_W-1:0]    r_lane;
  logic [TAP_W-1:0]     r_target;
  logic                 r_dir;
  logic                 r_err;
  logic [GAP_W-1:0]     r_gap;
  logic [TAP_W-1:0]     r_tap [NUM_LANES];
  logic [TAP_W-1:0]     w_req_cur, w_cur;
  logic [NUM_LANES-1:0] w_lane_oh;
  logic                 w_accept, w_req_bad, w_oor, w_gap_last;

  // Ready is held low until the first clock after reset release.
  assign o_req_ready = r_rdy_en & (r_state == S_IDLE);
  assign w_accept    = o_req_ready & i_req_valid;
  assign w_req_bad   = {1'b0, i_req_lane} >= LANE_LIM;
  assign w_oor       = |(i_delay_line_out_of_range & w_lane_oh);
  assign w_gap_last  = (r_gap == GAP_LAST);

  always_comb begin
    w_req_cur = '0;
    w_cur     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (i_req_lane == LANE_W'(i)) w_req_cur = r_tap[i];
      if (w_lane_oh[i])             w_cur     = r_tap[i];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign w_lane_oh[gi] = (r_lane == LANE_W'(gi));
      assign o_cur_tap[gi*TAP_W +: TAP_W] = r_tap[gi];
      assign o_delay_line_move[gi]      = w_lane_oh[gi] & (r_state == S_MOVE);
      assign o_delay_line_load[gi]      = w_lane_oh[gi] & (r_state == S_LOAD);
      assign o_delay_line_direction[gi] = w_lane_oh[gi] & r_dir &
                                          ((r_state == S_SETUP) | (r_state == S_MOVE) | (r_state == S_GAP));
    end
  endgenerate

  assign o_done     = (r_state == S_DONE);
  assign o_done_err = (r_state == S_DONE) & r_err;

  always_ff @(posedge i_fab_clk or posedge i_arst) begin
    if (i_arst) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_bad)                    w_state_next = S_DONE;
          else if (i_req_load)              w_state_next = S_LOAD;
          else if (w_req_cur == i_req_tap)  w_state_next = S_DONE;
          else                              w_state_next = S_SETUP;
        end
      end
      S_LOAD:  w_state_next = S_DONE;
      S_SETUP: w_state_next = S_MOVE;
      S_MOVE:  w_state_next = S_GAP;
      S_GAP: begin
        if (w_oor)           w_state_next = S_DONE;
        else if (w_gap_last) w_state_next = (w_cur == r_target) ? S_DONE : S_MOVE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_fab_clk or posedge i_arst) begin
    if (i_arst) begin
      r_rdy_en <= 1'b0;
      r_lane   <= '0;
      r_target <= '0;
      r_dir    <= 1'b0;
      r_err    <= 1'b0;
      r_gap    <= '0;
      for (int i = 0; i < NUM_LANES; i++) r_tap[i] <= TAP_INIT;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_accept) begin
        r_lane   <= i_req_lane;
        r_target <= i_req_tap;
        r_dir    <= (i_req_tap > w_req_cur);
        r_err    <= w_req_bad;
      end
      if (r_state == S_MOVE) r_gap <= '0;
      if (r_state == S_GAP)  r_gap <= r_gap + GAP_W'(1);
      if ((r_state == S_GAP) && w_oor) r_err <= 1'b1;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (w_lane_oh[i]) begin
          if (r_state == S_LOAD)
            r_tap[i] <= TAP_INIT;
          else if (r_state == S_MOVE)
            r_tap[i] <= r_dir ? r_tap[i] + TAP_W'(1) : r_tap[i] - TAP_W'(1);
          // An out-of-range flag means the IOD refused the last step, so undo it.
          else if ((r_state == S_GAP) && w_oor)
            r_tap[i] <= r_dir ? r_tap[i] - TAP_W'(1) : r_tap[i] + TAP_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr4_ca_dly_ctrl.sv
// Bench for ddr4_ca_dly_ctrl: per-request cycle schedule derived arithmetically,
// checked every cycle, plus literal pins from the directed cases.
module tb_ddr4_ca_dly_ctrl;
  localparam int NL = 14, TW = 8, INIT = 1, G = 2, LW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             valid = 1'b0;
  logic [LW-1:0]    lane  = '0;
  logic [TW-1:0]    tap   = '0;
  logic             load  = 1'b0;
  logic [NL-1:0]    oor   = '0;
  logic             ready, done, derr;
  logic [NL-1:0]    mv, dr, ld;
  logic [NL*TW-1:0] cur;

  ddr4_ca_dly_ctrl #(.NUM_LANES(NL), .TAP_W(TW), .TX_DELAY_INIT(INIT), .MOVE_GAP(G)) dut (
    .i_fab_clk(clk), .i_arst(rst), .i_req_valid(valid), .o_req_ready(ready),
    .i_req_lane(lane), .i_req_tap(tap), .i_req_load(load), .o_done(done), .o_done_err(derr),
    .o_delay_line_move(mv), .o_delay_line_direction(dr), .o_delay_line_load(ld),
    .i_delay_line_out_of_range(oor), .o_cur_tap(cur)
  );

  int total = 0, bad = 0;
  int cyc = 0, last_done_c = -1;
  logic chk_en = 1'b0;
  logic [3*NL+2:0]  exp_pins;
  logic [NL*TW-1:0] exp_cur;
  int mtap [NL];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("pins", {ready, done, derr, mv, dr, ld}, exp_pins);
      check("cur_tap", cur, exp_cur);
      if (done) last_done_c = cyc;
    end
  end

  function automatic logic [NL*TW-1:0] pack_cur(input int l, input int v);
    logic [NL*TW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*TW +: TW] = (i == l) ? TW'(v) : TW'(mtap[i]);
    return r;
  endfunction

  task automatic idle_cycle();
    logic [NL-1:0] z;
    z = '0;
    cyc = 0;
    valid = 1'b0;
    oor = NL'($urandom);
    exp_pins = {1'b1, 1'b0, 1'b0, z, z, z};
    exp_cur = pack_cur(-1, 0);
    @(posedge clk); #1;
  endtask

  // Drives one request from its accept cycle through DONE, setting the expected
  // outputs of every cycle from the request's arithmetic schedule.
  task automatic do_req(input int l, input int t, input bit ldq, input int oor_m, input bit hold);
    int start, n, sgn, d, m, fin, tapv, mb;
    bit inv, step, err, mvb, gapb;
    logic [NL-1:0] oh, r, z;
    z = '0;
    inv = (l >= NL);
    start = inv ? 0 : mtap[l];
    step = !inv && !ldq && (t != start);
    n = (t > start) ? t - start : start - t;
    sgn = (t > start) ? 1 : -1;
    m = (step && oor_m >= 1 && oor_m <= n) ? oor_m : 0;
    err = inv || (m != 0);
    if (!step)       d = (ldq && !inv) ? 2 : 1;
    else if (m != 0) d = 2 + (m - 1) * (G + 1) + 2;
    else             d = 2 + n * (G + 1);
    fin = inv ? 0 : ldq ? INIT : !step ? start : (m != 0) ? start + sgn * (m - 1) : t;
    oh = inv ? z : (NL'(1) << l);
    for (int c = 0; c <= d; c++) begin
      cyc = c;
      valid = (c == 0) || hold;
      lane  = (c == 0) ? LW'(l) : LW'($urandom);
      tap   = (c == 0) ? TW'(t) : TW'($urandom);
      load  = (c == 0) ? ldq : 1'($urandom);
      mvb  = step && c >= 2 && c < d && ((c - 2) % (G + 1) == 0);
      gapb = step && c >= 2 && c < d && !mvb;
      r = NL'($urandom);
      if (gapb) r[l] = (m != 0) && (c == 2 + (m - 1) * (G + 1) + 1);
      oor = r;
      mb = (c <= 2) ? 0 : (c - 3) / (G + 1) + 1;
      if (mb > n) mb = n;
      tapv = (c >= d) ? fin : step ? start + sgn * mb : start;
      exp_pins = {c == 0, c == d, (c == d) && err,
                  mvb ? oh : z,
                  (step && t > start && c >= 1 && c < d) ? oh : z,
                  (ldq && !inv && c == 1) ? oh : z};
      exp_cur = pack_cur(inv ? -1 : l, tapv);
      @(posedge clk); #1;
    end
    if (!inv) mtap[l] = fin;
  endtask

  initial begin
    for (int i = 0; i < NL; i++) mtap[i] = INIT;
    exp_pins = '0;
    exp_cur = pack_cur(-1, 0);
    chk_en = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    idle_cycle();

    // Increment lane 3 from 1 to 4.
    last_done_c = -1;
    do_req(3, 4, 1'b0, 0, 1'b0);
    check("inc_done_cycle", last_done_c, 11);
    check("inc_lane3_tap", cur[3*TW +: TW], 8'd4);
    idle_cycle();

    // Lane 0 up to 4, down to 2, then an immediate zero-step.
    do_req(0, 4, 1'b0, 0, 1'b0);
    idle_cycle();
    last_done_c = -1;
    do_req(0, 2, 1'b0, 0, 1'b0);
    check("dec_done_cycle", last_done_c, 8);
    last_done_c = -1;
    do_req(0, 2, 1'b0, 0, 1'b0);
    check("zero_done_cycle", last_done_c, 1);
    check("dec_lane0_tap", cur[0*TW +: TW], 8'd2);
    idle_cycle();

    // Lane 13 to 10, then reload.
    do_req(13, 10, 1'b0, 0, 1'b0);
    last_done_c = -1;
    do_req(13, 0, 1'b1, 0, 1'b0);
    check("load_done_cycle", last_done_c, 2);
    check("load_lane13_tap", cur[13*TW +: TW], 8'd1);
    idle_cycle();

    // Out-of-range in the gap after the third pulse.
    last_done_c = -1;
    do_req(5, 200, 1'b0, 3, 1'b0);
    check("oor_done_cycle", last_done_c, 10);
    check("oor_lane5_tap", cur[5*TW +: TW], 8'd3);
    idle_cycle();

    // Invalid lane, then a request held through a busy move.
    last_done_c = -1;
    do_req(14, 7, 1'b0, 0, 1'b0);
    check("bad_lane_done_cycle", last_done_c, 1);
    do_req(7, 20, 1'b0, 0, 1'b1);
    do_req(7, 15, 1'b0, 0, 1'b0);
    check("bp_lane7_tap", cur[7*TW +: TW], 8'd15);
    idle_cycle();

    for (int k = 0; k < 150; k++) begin
      int l, t, m;
      bit ldq, hold;
      l = int'($urandom_range(0, 15));
      ldq = ($urandom_range(0, 99) < 15);
      hold = ($urandom_range(0, 3) == 0);
      m = 0;
      if (l < NL) begin
        t = mtap[l] + int'($urandom_range(0, 24)) - 12;
        if (t < 0) t = 0;
        if (t > 255) t = 255;
      end else begin
        t = int'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 4) == 0) m = int'($urandom_range(1, 6));
      do_req(l, t, ldq, m, hold);
      if (!hold) repeat ($urandom_range(0, 2)) idle_cycle();
    end
    idle_cycle();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
